// File: rtl/soc_decerr_responder_pkg.sv
// Shared constants and helpers for the default-slave DECERR responder.
// Response encodings, the R data filler pattern and the error-counter adder.
package soc_decerr_responder_pkg;

    localparam logic [1:0]  RESP_DECERR    = 2'b11;
    localparam logic [63:0] DecErrRespData = 64'hCA11_AB1E_BAD_CAB1E;

    // Error counter adds 0..2 per cycle and sticks at all-ones
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO, port-compatible subset of the common_cells fifo_v3.
// Clears on rst_ni low or flush_i high at the clock edge.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned           CntW    = ADDR_DEPTH + 1;
    localparam logic [CntW-1:0]       FullCnt = CntW'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr_r;
    logic [ADDR_DEPTH-1:0] wr_ptr_r;
    logic [CntW-1:0]       cnt_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  bypass_s;

    assign full_o   = (cnt_r == FullCnt);
    assign empty_o  = (cnt_r == '0);
    // In fall-through mode a push into an empty FIFO that is popped at once never lands in memory
    assign bypass_s = FALL_THROUGH & empty_o & push_i & pop_i;
    assign push_s   = push_i & ~full_o & ~bypass_s;
    assign pop_s    = pop_i & ~empty_o;
    assign data_o   = (FALL_THROUGH && empty_o) ? data_i : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == LastPtr) ? '0 : wr_ptr_r + ADDR_DEPTH'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LastPtr) ? '0 : rd_ptr_r + ADDR_DEPTH'(1);
            end
            cnt_r <= cnt_r + CntW'(push_s) - CntW'(pop_s);
        end
    end

    // Storage array
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/soc_decerr_responder.sv
// AXI4 default slave: drains writes and answers every burst with DECERR so stray
// accesses cannot hang the crossbar; logs the last offending address and a count.
module soc_decerr_responder
    import soc_decerr_responder_pkg::*;
#(
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned MaxWrTxn  = 4,
    parameter logic [63:0] RespData  = DecErrRespData
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [15:0]          err_cnt_o
);

    typedef enum logic {W_IDLE, W_DATA} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    localparam logic [DataWidth-1:0] RData = DataWidth'(RespData);

    wstate_e              w_state_r, w_state_s;
    rstate_e              r_state_r, r_state_s;
    logic [IdWidth-1:0]   aw_id_r;
    logic [IdWidth-1:0]   ar_id_r;
    logic [7:0]           ar_len_r;
    logic [7:0]           beat_cnt_r;
    logic [AddrWidth-1:0] err_addr_r;
    logic [15:0]          err_cnt_r;
    logic                 fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
    logic [IdWidth-1:0]   fifo_head_s;
    logic                 aw_hs_s, ar_hs_s, r_hs_s;

    assign aw_hs_s = aw_valid_i & aw_ready_o;
    assign ar_hs_s = ar_valid_i & ar_ready_o;
    assign r_hs_s  = r_valid_o & r_ready_i;

    // Write FSM: one AW at a time, W beats drained until last, then the ID is queued for B
    always_comb begin
        w_state_s   = w_state_r;
        aw_ready_o  = 1'b0;
        w_ready_o   = 1'b0;
        fifo_push_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                aw_ready_o = ~fifo_full_s & ~rst_i;
                if (aw_valid_i && aw_ready_o) begin
                    w_state_s = W_DATA;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_DATA: begin
                w_ready_o = ~rst_i;
                if (w_valid_i && w_ready_o && w_last_i) begin
                    fifo_push_s = 1'b1;
                    w_state_s   = W_IDLE;
                end else begin
                    w_state_s = W_DATA;
                end
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write FSM state and captured AW ID
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_r <= W_IDLE;
            aw_id_r   <= '0;
        end else begin
            w_state_r <= w_state_s;
            if (aw_hs_s) begin
                aw_id_r <= aw_id_i;
            end
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IdWidth),
        .DEPTH        (MaxWrTxn)
    ) i_b_fifo (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .flush_i (rst_i),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .data_i  (aw_id_r),
        .push_i  (fifo_push_s),
        .data_o  (fifo_head_s),
        .pop_i   (fifo_pop_s)
    );

    // Non-valid B/R beats present zeros so idle buses stay quiet
    assign b_valid_o  = ~fifo_empty_s & ~rst_i;
    assign b_id_o     = b_valid_o ? fifo_head_s : '0;
    assign b_resp_o   = b_valid_o ? RESP_DECERR : 2'b00;
    assign fifo_pop_s = b_valid_o & b_ready_i;

    // Read FSM: accept AR, then stream len+1 DECERR beats
    always_comb begin
        r_state_s  = r_state_r;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                ar_ready_o = ~rst_i;
                if (ar_valid_i && ar_ready_o) begin
                    r_state_s = R_DATA;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                r_valid_o = ~rst_i;
                r_last_o  = r_valid_o & (beat_cnt_r == ar_len_r);
                if (r_valid_o && r_ready_i && r_last_o) begin
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    assign r_id_o   = r_valid_o ? ar_id_r : '0;
    assign r_data_o = r_valid_o ? RData : '0;
    assign r_resp_o = r_valid_o ? RESP_DECERR : 2'b00;

    // Read FSM state, burst context and beat counter (held at len on the final beat)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_r  <= R_IDLE;
            ar_id_r    <= '0;
            ar_len_r   <= 8'd0;
            beat_cnt_r <= 8'd0;
        end else begin
            r_state_r <= r_state_s;
            if (ar_hs_s) begin
                ar_id_r    <= ar_id_i;
                ar_len_r   <= ar_len_i;
                beat_cnt_r <= 8'd0;
            end else if (r_hs_s && !r_last_o) begin
                beat_cnt_r <= beat_cnt_r + 8'd1;
            end
        end
    end

    // Error log: AR address wins a same-cycle tie, counter adds both accepts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_addr_r <= '0;
            err_cnt_r  <= 16'd0;
        end else begin
            if (ar_hs_s) begin
                err_addr_r <= ar_addr_i;
            end else if (aw_hs_s) begin
                err_addr_r <= aw_addr_i;
            end
            err_cnt_r <= sat_add16(err_cnt_r, {1'b0, aw_hs_s} + {1'b0, ar_hs_s});
        end
    end

    assign err_addr_o = err_addr_r;
    assign err_cnt_o  = err_cnt_r;

endmodule

// File: tb/tb_soc_decerr_responder.sv
// Scoreboard bench: drivers issue directed and random AXI traffic, a negedge monitor
// compares every DUT output against a queue-based model of the responder's behaviour.
module tb_soc_decerr_responder;

    localparam int IDW   = 5;
    localparam int DW    = 64;
    localparam int AW    = 64;
    localparam int MAXWR = 4;
    localparam logic [63:0] EXP_DATA = 64'hCA11AB1EBADCAB1E;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
    } rbeat_t;

    logic           clk        = 1'b0;
    logic           rst_i      = 1'b1;
    logic           aw_valid_i = 1'b0;
    logic [IDW-1:0] aw_id_i    = '0;
    logic [AW-1:0]  aw_addr_i  = '0;
    logic           w_valid_i  = 1'b0;
    logic           w_last_i   = 1'b0;
    logic           b_ready_i  = 1'b0;
    logic           ar_valid_i = 1'b0;
    logic [IDW-1:0] ar_id_i    = '0;
    logic [AW-1:0]  ar_addr_i  = '0;
    logic [7:0]     ar_len_i   = 8'd0;
    logic           r_ready_i  = 1'b0;
    logic           aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o;
    logic [IDW-1:0] b_id_o, r_id_o;
    logic [1:0]     b_resp_o, r_resp_o;
    logic [DW-1:0]  r_data_o;
    logic [AW-1:0]  err_addr_o;
    logic [15:0]    err_cnt_o;

    int  checks  = 0;
    int  fails   = 0;
    int  tmo_cnt = 0;
    bit  done    = 1'b0;
    bit  abort   = 1'b0;
    bit  gaps_on = 1'b0;
    int  b_mode  = 3;   // 0 always ready, 1 toggle, 2 random, 3 hold low
    int  r_mode  = 0;   // 0 always ready, 1 toggle, 2 random

    // model state, written only by the monitor
    logic [IDW-1:0] bq[$];
    rbeat_t         rq[$];
    bit             w_busy  = 1'b0;
    logic [IDW-1:0] cur_wid = '0;
    logic [63:0]    exp_addr = 64'd0;
    int             exp_cnt  = 0;

    soc_decerr_responder #(
        .IdWidth(IDW), .DataWidth(DW), .AddrWidth(AW), .MaxWrTxn(MAXWR), .RespData(64'hCA11_AB1E_BAD_CAB1E)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (b_mode)
            0:       b_ready_i = 1'b1;
            1:       b_ready_i = ~b_ready_i;
            2:       b_ready_i = 1'($urandom_range(0, 1));
            default: b_ready_i = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        #1;
        case (r_mode)
            0:       r_ready_i = 1'b1;
            1:       r_ready_i = ~r_ready_i;
            default: r_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t (required to finish earlier)", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // waits for a ready on channel ch (0 AW, 1 W, 2 AR); entered and left just after a posedge
    task automatic wait_hs(input int ch);
        int n;
        bit hs;
        n = 0;
        forever begin
            @(negedge clk);
            case (ch)
                0:       hs = aw_ready_o;
                1:       hs = w_ready_o;
                default: hs = ar_ready_o;
            endcase
            @(posedge clk);
            #1;
            if (hs || abort) break;
            n++;
            if (n > 2000) begin
                tmo_cnt++;
                $display("FAIL hs_wait ch%0d: no ready after %0d cycles, required within 2000", ch, n);
                break;
            end
        end
    endtask

    task automatic write_txn(input logic [IDW-1:0] id, input logic [63:0] addr, input int beats, input bit early);
        aw_valid_i = 1'b1;
        aw_id_i    = id;
        aw_addr_i  = addr;
        if (early) begin
            w_valid_i = 1'b1;
            w_last_i  = (beats == 1);
        end
        wait_hs(0);
        aw_valid_i = 1'b0;
        if (abort) begin
            w_valid_i = 1'b0;
            w_last_i  = 1'b0;
            return;
        end
        for (int b = 0; b < beats; b++) begin
            w_valid_i = 1'b1;
            w_last_i  = (b == beats - 1);
            wait_hs(1);
            w_valid_i = 1'b0;
            w_last_i  = 1'b0;
            if (abort) return;
            if (gaps_on) idle($urandom_range(0, 2));
        end
    endtask

    task automatic read_txn(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len);
        ar_valid_i = 1'b1;
        ar_id_i    = id;
        ar_addr_i  = addr;
        ar_len_i   = len;
        wait_hs(2);
        ar_valid_i = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin : monitor
        bit rst_prev, e_awr, e_wr, e_arr, e_bv, e_rv, aw_hs, w_hs, ar_hs;
        rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("hs_timeouts", 64'(tmo_cnt), 64'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                $finish;
            end else if (rst_i) begin
                chk("rst_aw_ready", 64'(aw_ready_o), 64'd0);
                chk("rst_w_ready", 64'(w_ready_o), 64'd0);
                chk("rst_ar_ready", 64'(ar_ready_o), 64'd0);
                chk("rst_b_valid", 64'(b_valid_o), 64'd0);
                chk("rst_r_valid", 64'(r_valid_o), 64'd0);
                chk("rst_b_id", 64'(b_id_o), 64'd0);
                chk("rst_b_resp", 64'(b_resp_o), 64'd0);
                chk("rst_r_id", 64'(r_id_o), 64'd0);
                chk("rst_r_data", r_data_o, 64'd0);
                chk("rst_r_resp", 64'(r_resp_o), 64'd0);
                chk("rst_r_last", 64'(r_last_o), 64'd0);
                if (rst_prev) begin
                    chk("rst_err_addr", err_addr_o, 64'd0);
                    chk("rst_err_cnt", 64'(err_cnt_o), 64'd0);
                end
                bq.delete();
                rq.delete();
                w_busy   = 1'b0;
                exp_addr = 64'd0;
                exp_cnt  = 0;
                rst_prev = 1'b1;
            end else begin
                rst_prev = 1'b0;
                e_awr = !w_busy && (bq.size() < MAXWR);
                e_wr  = w_busy;
                e_arr = (rq.size() == 0);
                e_bv  = (bq.size() != 0);
                e_rv  = (rq.size() != 0);
                chk("aw_ready", 64'(aw_ready_o), 64'(e_awr));
                chk("w_ready", 64'(w_ready_o), 64'(e_wr));
                chk("ar_ready", 64'(ar_ready_o), 64'(e_arr));
                chk("b_valid", 64'(b_valid_o), 64'(e_bv));
                chk("r_valid", 64'(r_valid_o), 64'(e_rv));
                if (e_bv) begin
                    chk("b_id", 64'(b_id_o), 64'(bq[0]));
                    chk("b_resp", 64'(b_resp_o), 64'd3);
                end
                if (e_rv) begin
                    chk("r_id", 64'(r_id_o), 64'(rq[0].id));
                    chk("r_data", r_data_o, EXP_DATA);
                    chk("r_resp", 64'(r_resp_o), 64'd3);
                    chk("r_last", 64'(r_last_o), 64'(rq[0].last));
                end
                chk("err_addr", err_addr_o, exp_addr);
                chk("err_cnt", 64'(err_cnt_o), 64'(exp_cnt));
                aw_hs = aw_valid_i && e_awr;
                w_hs  = w_valid_i && e_wr;
                ar_hs = ar_valid_i && e_arr;
                if (e_bv && b_ready_i) void'(bq.pop_front());
                if (e_rv && r_ready_i) void'(rq.pop_front());
                if (w_hs && w_last_i) begin
                    bq.push_back(cur_wid);
                    w_busy = 1'b0;
                end
                if (aw_hs) begin
                    w_busy  = 1'b1;
                    cur_wid = aw_id_i;
                end
                if (ar_hs) begin
                    for (int i = 0; i <= int'(ar_len_i); i++) rq.push_back({ar_id_i, (i == int'(ar_len_i))});
                end
                if (ar_hs) exp_addr = ar_addr_i;
                else if (aw_hs) exp_addr = aw_addr_i;
                exp_cnt = exp_cnt + int'(aw_hs) + int'(ar_hs);
                if (exp_cnt > 65535) exp_cnt = 65535;
            end
        end
    end

    // stimulus
    initial begin
        idle(3);
        rst_i = 1'b0;
        b_mode = 0;
        idle(2);

        read_txn(5'd3, 64'h5000_0000, 8'd0);
        idle(4);

        r_mode = 1;
        read_txn(5'd4, 64'h5100_0000, 8'd7);
        idle(25);
        r_mode = 0;

        write_txn(5'd5, 64'h5200_0000, 4, 1'b0);
        idle(4);

        // fill the pending-B FIFO, stall the fifth AW, release it with a single pop
        b_mode = 3;
        fork
            begin
                for (int k = 0; k < 5; k++) write_txn(5'(10 + k), 64'h5300_0000 + 64'(k), 1, 1'b0);
            end
            begin
                idle(30);
                #1;
                b_mode = 0;
                idle(1);
                b_mode = 3;
                idle(8);
                b_mode = 0;
            end
        join
        idle(10);

        fork
            write_txn(5'd7, 64'h6000_0000, 2, 1'b1);
            read_txn(5'd9, 64'h7000_0000, 8'd3);
        join
        idle(10);

        b_mode  = 2;
        r_mode  = 2;
        gaps_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++)
                    write_txn(5'($urandom), {32'($urandom), 32'($urandom)}, $urandom_range(1, 8), 1'($urandom_range(0, 1)));
            end
            begin
                for (int k = 0; k < 40; k++)
                    read_txn(5'($urandom), {32'($urandom), 32'($urandom)}, 8'($urandom_range(0, 15)));
            end
        join
        idle(60);

        // leave pending B entries and in-flight bursts, then reset in the middle
        b_mode = 3;
        write_txn(5'd20, 64'h8000_0000, 1, 1'b0);
        write_txn(5'd21, 64'h8000_0010, 1, 1'b0);
        r_mode = 1;
        fork
            read_txn(5'd1, 64'h8100_0000, 8'd255);
            write_txn(5'd2, 64'h8200_0000, 100, 1'b0);
            begin
                idle(15);
                #2;
                rst_i = 1'b1;
                abort = 1'b1;
                idle(2);
                rst_i = 1'b0;
            end
        join
        abort = 1'b0;
        b_mode = 0;
        r_mode = 0;
        gaps_on = 1'b0;
        idle(5);

        // drive the error counter to 0xFFFE, then three more accepts
        for (int k = 0; k < 32767; k++) begin
            fork
                write_txn(5'(k), 64'h9000_0000 + 64'(k), 1, 1'b0);
                read_txn(5'(k + 1), 64'hA000_0000 + 64'(k), 8'd0);
            join
        end
        fork
            write_txn(5'd30, 64'hB000_0000, 1, 1'b0);
            read_txn(5'd31, 64'hB100_0000, 8'd0);
        join
        read_txn(5'd29, 64'hB200_0000, 8'd0);
        idle(6);
        done = 1'b1;
    end

endmodule
